// File: rtl/shift_add_mult_4bit.sv
// Sequential unsigned shift-and-add multiplier. One partial product per clock
// goes through an external WIDTH-bit adder; the product is held until the next done.
module shift_add_mult_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // Adder operands come only from registers, so the external adder closes no loop.
    assign add_a   = a_q;
    assign add_b   = (state_q == S_CALC && q_q[0]) ? m_q : '0;
    assign add_cin = 1'b0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Carry becomes the new accumulator MSB; the consumed Q bit drops out.
                {a_d, q_d} = {add_cout, add_sum, q_q[WIDTH-1:1]};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = {a_q, q_q};
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// Directed bench for shift_add_mult_4bit; the attached 4-bit adder is modelled
// as a plain combinational sum.
module tb_shift_add_mult_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] last_prod = '0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    shift_add_mult_4bit #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [3:0] m, input logic [3:0] q);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_add_b", 32'(add_b), 32'(0));
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("idle_done", 32'(done), 32'(0));
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_product", 32'(product), 32'(last_prod));
        end
    endtask

    // c indexes the negedge after edge Ec, E0 being the accept edge.
    task automatic track(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                         input bit hold, input int pulse_at,
                         input logic [3:0] nm, input logic [3:0] nq);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = hold;
            if (c == pulse_at) begin
                start        = 1'b1;
                multiplicand = 4'h2;
                multiplier   = 4'h2;
            end
            check("add_cin", 32'(add_cin), 32'(0));
            if (c < 5) begin
                check("busy", 32'(busy), 32'(1));
                check("done_early", 32'(done), 32'(0));
                check("product_hold", 32'(product), 32'(last_prod));
            end else begin
                check("busy_fall", 32'(busy), 32'(0));
                check("done_pulse", 32'(done), 32'(1));
                check("product", 32'(product), 32'(exp));
            end
            if (c < 4)
                check("add_b_calc", 32'(add_b), q[c] ? 32'(m) : 32'(0));
            else
                check("add_b_rest", 32'(add_b), 32'(0));
            if (m == 4'hF && q == 4'hF && c == 1) begin
                check("ff_add_a", 32'(add_a), 32'(7));
                check("ff_add_sum", 32'(add_sum), 32'(6));
                check("ff_add_cout", 32'(add_cout), 32'(1));
            end
            if (hold && c == 5) begin
                multiplicand = nm;
                multiplier   = nq;
            end
        end
        last_prod = exp;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_product", 32'(product), 32'(0));
        check("rst_add_a", 32'(add_a), 32'(0));
        check("rst_add_b", 32'(add_b), 32'(0));
        check("rst_add_cin", 32'(add_cin), 32'(0));
        rst_n = 1'b1;

        issue(4'hA, 4'h3);
        track(4'hA, 4'h3, 8'h1E, 1'b0, -1, 4'h0, 4'h0);
        idle_cycles(1);

        issue(4'hF, 4'hF);
        track(4'hF, 4'hF, 8'hE1, 1'b0, -1, 4'h0, 4'h0);

        issue(4'h0, 4'hF);
        track(4'h0, 4'hF, 8'h00, 1'b0, -1, 4'h0, 4'h0);

        issue(4'h9, 4'h0);
        track(4'h9, 4'h0, 8'h00, 1'b0, -1, 4'h0, 4'h0);

        issue(4'h5, 4'h5);
        track(4'h5, 4'h5, 8'h19, 1'b0, 1, 4'h0, 4'h0);
        idle_cycles(6);

        // Abort between E2 and E3.
        issue(4'h7, 4'h6);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_product", 32'(product), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = '0;
        idle_cycles(8);

        issue(4'h3, 4'h4);
        track(4'h3, 4'h4, 8'h0C, 1'b0, -1, 4'h0, 4'h0);

        issue(4'h2, 4'h3);
        track(4'h2, 4'h3, 8'h06, 1'b1, -1, 4'hC, 4'hB);
        track(4'hC, 4'hB, 8'h84, 1'b0, -1, 4'h0, 4'h0);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
